// File: rtl/result_pkg.sv
// Shared types and helpers for the systolic-array result buffer.
package result_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } rb_state_t;

  // Column j leaves the array j cycles after column 0, so it needs N-1-j delay stages.
  function automatic int unsigned deskew_depth(input int unsigned n, input int unsigned j);
    return n - 1 - j;
  endfunction

endpackage

// File: rtl/result_buffer_row_fifo.sv
// Circular row FIFO with explicit occupancy count; head row is always presented on rdata.
module row_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wptr;
  logic [PTR_W-1:0]            rptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= (wptr == PTR_W'(DEPTH-1)) ? '0 : wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= (rptr == PTR_W'(DEPTH-1)) ? '0 : rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_buffer.sv
// De-skews partial sums from the systolic array bottom row, buffers one result
// matrix in a row FIFO and drains it over valid/ready, pulsing done at the end.
module result_buffer
  import result_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] psum_in  [MATRIX_SIZE],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data [MATRIX_SIZE],
  output logic                 busy,
  output logic                 done
);

  localparam int ROW_W  = MATRIX_SIZE * DATA_SIZE;
  localparam int CNT_W  = $clog2(MATRIX_SIZE+1);
  localparam int FCNT_W = $clog2(DEPTH+1);

  if (DEPTH < MATRIX_SIZE) begin : g_depth_check
    $error("result_buffer: DEPTH must be >= MATRIX_SIZE");
  end

  rb_state_t         state;
  logic [CNT_W-1:0]  row_cnt;
  logic              collect;
  logic              row_valid;
  logic              push;
  logic              pop;
  logic [ROW_W-1:0]  wrow;
  logic [ROW_W-1:0]  rrow;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FCNT_W-1:0] fifo_count;

  assign collect = (state == COLLECT);

  // Valid is gated at entry so rows presented outside COLLECT never reach the FIFO.
  if (MATRIX_SIZE > 1) begin : g_vpipe
    localparam int VW = MATRIX_SIZE - 1;
    logic [VW-1:0] vpipe;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) vpipe <= '0;
      else       vpipe <= (vpipe << 1) | VW'(in_valid && collect);
    end

    assign row_valid = vpipe[VW-1];
  end else begin : g_vdirect
    assign row_valid = in_valid && collect;
  end

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned D = deskew_depth(MATRIX_SIZE, j);

    if (D == 0) begin : g_pass
      assign wrow[j*DATA_SIZE +: DATA_SIZE] = psum_in[j];
    end else begin : g_dly
      logic [D-1:0][DATA_SIZE-1:0] sr;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= (sr << DATA_SIZE) | (D*DATA_SIZE)'(psum_in[j]);
      end

      assign wrow[j*DATA_SIZE +: DATA_SIZE] = sr[D-1];
    end

    assign out_data[j] = rrow[j*DATA_SIZE +: DATA_SIZE];
  end

  assign push      = row_valid && collect && !fifo_full;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  row_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ROW_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(wrow),
    .rdata(rrow),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= COLLECT;
            row_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        COLLECT: begin
          if (push) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == CNT_W'(MATRIX_SIZE-1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: table-driven N=2 jobs, mid-job reset, and N=4 jobs with pointer wrap.
module tb_result_buffer;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start2, in_valid2, out_valid2, out_ready2, busy2, done2;
  logic [31:0] p2  [2];
  logic [31:0] od2 [2];
  logic        start4, in_valid4, out_valid4, out_ready4, busy4, done4;
  logic [31:0] p4  [4];
  logic [31:0] od4 [4];

  result_buffer #(.MATRIX_SIZE(2), .DATA_SIZE(32), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .psum_in(p2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(od2), .busy(busy2), .done(done2)
  );

  result_buffer #(.MATRIX_SIZE(4), .DATA_SIZE(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid4), .psum_in(p4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(od4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [31:0] a0, a1, b0, b1;
    int          mode;     // 0: ready high, 1: ready low for 10 cycles, 2: ready toggles
    bit          junk;
    bit          restart;
  } vec2_t;

  vec2_t        vecs [5];
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  int           mode2 = 0, mode4 = 0, stall_at2 = 0;
  int           done_cnt2 = 0, done_cnt4 = 0, rows_out2 = 0, rows_out4 = 0;
  logic [63:0]  q2 [$];
  logic [127:0] q4 [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mode2 == 0)      out_ready2 = 1'b1;
      else if (mode2 == 1) out_ready2 = (cyc >= stall_at2);
      else                 out_ready2 = ~out_ready2;
      if (mode4 == 0) out_ready4 = 1'b1;
      else            out_ready4 = ~out_ready4;
    end
  endtask

  task automatic mon2();
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid2 && out_ready2) begin
          rows_out2++;
          if (q2.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL row2_unexpected: got %0h expected no row", {od2[1], od2[0]});
          end else begin
            exp = q2.pop_front();
            check("row2", {od2[1], od2[0]}, exp);
          end
        end
        if (done2) begin
          done_cnt2++;
          check("busy2_at_done", busy2, 1'b0);
        end
      end
    end
  endtask

  task automatic mon4();
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid4 && out_ready4) begin
          rows_out4++;
          if (q4.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL row4_unexpected: got %0h expected no row", {od4[3], od4[2], od4[1], od4[0]});
          end else begin
            exp = q4.pop_front();
            check("row4", {od4[3], od4[2], od4[1], od4[0]}, exp);
          end
        end
        if (done4) begin
          done_cnt4++;
          check("busy4_at_done", busy4, 1'b0);
        end
      end
    end
  endtask

  task automatic wait_done2();
    for (int n = 0; n < 60 && done_cnt2 == 0; n++) @(negedge clk);
    if (done_cnt2 == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done2_timeout: got no done expected done within 60 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done4();
    for (int n = 0; n < 80 && done_cnt4 == 0; n++) @(negedge clk);
    if (done_cnt4 == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done4_timeout: got no done expected done within 80 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_job2(input vec2_t v);
    logic [63:0] ra, rb;
    ra = {v.a1, v.a0};
    rb = {v.b1, v.b0};
    done_cnt2 = 0;
    rows_out2 = 0;
    mode2     = v.mode;
    stall_at2 = cyc + 10;
    if (v.junk) begin
      in_valid2 = 1'b1; p2[0] = 32'd99; p2[1] = 32'd99;
      step(); step();
      in_valid2 = 1'b0;
    end
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    // c=0: column 0 of row a
    in_valid2 = 1'b1; p2[0] = v.a0; p2[1] = 32'hDEAD0000;
    q2.push_back(ra);
    @(negedge clk);
    check("lat2_c0_valid", out_valid2, 1'b0);
    step();
    // c=1: column 0 of row b, column 1 of row a
    p2[0] = v.b0; p2[1] = v.a1;
    q2.push_back(rb);
    if (v.restart) start2 = 1'b1;
    @(negedge clk);
    check("lat2_c1_valid", out_valid2, 1'b0);
    step();
    // c=2: column 1 of row b
    in_valid2 = 1'b0; start2 = 1'b0; p2[0] = '0; p2[1] = v.b1;
    @(negedge clk);
    check("lat2_c2_valid", out_valid2, 1'b1);
    check("lat2_c2_data", {od2[1], od2[0]}, ra);
    step();
    p2[1] = '0;
    if (v.junk) begin
      in_valid2 = 1'b1; p2[0] = 32'd99; p2[1] = 32'd99;
      step(); step();
      in_valid2 = 1'b0; p2[0] = '0; p2[1] = '0;
    end
    if (v.mode == 1) begin
      while (cyc < stall_at2 - 2) @(negedge clk);
      @(negedge clk);
      check("stall2_valid", out_valid2, 1'b1);
      check("stall2_data", {od2[1], od2[0]}, ra);
      check("stall2_no_pop", rows_out2, 0);
    end
    wait_done2();
    check("job2_done_count", done_cnt2, 1);
    check("job2_rows", rows_out2, 2);
    check("job2_queue_left", q2.size(), 0);
    check("job2_busy_end", busy2, 1'b0);
    check("job2_valid_end", out_valid2, 1'b0);
  endtask

  task automatic run_job4(input int base);
    logic [127:0] row;
    done_cnt4 = 0;
    rows_out4 = 0;
    mode4     = 2;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid4 = (c < 4);
      for (int j = 0; j < 4; j++) begin
        if (c - j >= 0 && c - j < 4) p4[j] = base + (c - j) * 4 + j + 1;
        else                         p4[j] = 32'hBAD;
      end
      if (c < 4) begin
        row = '0;
        for (int j = 0; j < 4; j++) row[j*32 +: 32] = base + c * 4 + j + 1;
        q4.push_back(row);
      end
      if (c == 3) begin
        @(negedge clk);
        check("lat4_c3_valid", out_valid4, 1'b0);
      end
      if (c == 4) begin
        @(negedge clk);
        check("lat4_c4_valid", out_valid4, 1'b1);
      end
      step();
    end
    in_valid4 = 1'b0;
    for (int j = 0; j < 4; j++) p4[j] = '0;
    wait_done4();
    check("job4_done_count", done_cnt4, 1);
    check("job4_rows", rows_out4, 4);
    check("job4_queue_left", q4.size(), 0);
    check("job4_busy_end", busy4, 1'b0);
  endtask

  initial begin
    vec2_t v;
    vecs[0] = '{a0: 32'd10, a1: 32'd20, b0: 32'd30, b1: 32'd40, mode: 0, junk: 1'b0, restart: 1'b0};
    vecs[1] = '{a0: 32'd10, a1: 32'd20, b0: 32'd30, b1: 32'd40, mode: 1, junk: 1'b0, restart: 1'b0};
    vecs[2] = '{a0: 32'd1,  a1: 32'd2,  b0: 32'd3,  b1: 32'd4,  mode: 0, junk: 1'b1, restart: 1'b0};
    vecs[3] = '{a0: 32'd5,  a1: 32'd6,  b0: 32'd7,  b1: 32'd8,  mode: 2, junk: 1'b0, restart: 1'b1};
    vecs[4] = '{a0: 32'hFFFFFFFF, a1: 32'h0, b0: 32'h80000000, b1: 32'h7FFFFFFF,
                mode: 0, junk: 1'b1, restart: 1'b1};

    reset = 1'b1;
    start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    start4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    for (int j = 0; j < 2; j++) p2[j] = '0;
    for (int j = 0; j < 4; j++) p4[j] = '0;

    fork
      drive_ready();
      mon2();
      mon4();
    join_none

    repeat (2) @(negedge clk);
    check("rst_busy2", busy2, 1'b0);
    check("rst_done2", done2, 1'b0);
    check("rst_valid2", out_valid2, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_valid4", out_valid4, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_job2(vecs[i]);

    // Reset lands while the first row sits unread in the FIFO.
    done_cnt2 = 0;
    mode2 = 1;
    stall_at2 = cyc + 1000;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    in_valid2 = 1'b1; p2[0] = 32'd55; p2[1] = '0;
    q2.push_back({32'd66, 32'd55});
    step();
    in_valid2 = 1'b0; p2[0] = '0; p2[1] = 32'd66;
    step();
    p2[1] = '0;
    for (int n = 0; n < 10 && !out_valid2; n++) @(negedge clk);
    check("midrst_row_visible", out_valid2, 1'b1);
    check("midrst_row_data", {od2[1], od2[0]}, {32'd66, 32'd55});
    @(posedge clk);
    #2 reset = 1'b1;
    q2.delete();
    #1;
    check("midrst_valid", out_valid2, 1'b0);
    check("midrst_busy", busy2, 1'b0);
    check("midrst_done", done2, 1'b0);
    mode2 = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("midrst_no_done", done_cnt2, 0);
    v = '{a0: 32'd111, a1: 32'd222, b0: 32'd333, b1: 32'd444, mode: 0, junk: 1'b0, restart: 1'b0};
    run_job2(v);

    run_job4(0);
    run_job4(256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
# result_buffer

Output-side companion to the weight buffer in the systolic-array datapath. It captures partial sums leaving the bottom row of the array, where column j emerges j cycles after column 0. It de-skews the columns into aligned result rows, stores one matrix of results in a small FIFO, and drains the rows to the consumer over a valid/ready handshake, then signals job completion.

## Interface

Parameters:
- MATRIX_SIZE, 2, array dimension N: number of columns per row and rows per job.
- DATA_SIZE, 32, width of each partial-sum element.
- DEPTH, 4, FIFO depth in rows. Must satisfy DEPTH >= MATRIX_SIZE; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a job when the block is in IDLE, ignored otherwise.
- in_valid  input  1  qualifies psum_in[0] this cycle; psum_in[j] for the same row is sampled j cycles later.
- psum_in  input  [DATA_SIZE-1:0] x MATRIX_SIZE (unpacked)  skewed partial sums from the array bottom row.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  consumer accepts out_data when high together with out_valid.
- out_data  output  [DATA_SIZE-1:0] x MATRIX_SIZE (unpacked)  head row of the FIFO.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when a job fully drains.

## Operation

- FSM states are IDLE, COLLECT and DRAIN.
  - IDLE -> COLLECT on start.
  - COLLECT -> DRAIN on the edge that writes row N-1.
  - DRAIN -> IDLE on the first edge where the FIFO is empty and no pop occurs. done is high for exactly the cycle following that transition.
- De-skew:
  - Column j passes through N-1-j registers. Column N-1 is used undelayed.
  - in_valid, gated with state==COLLECT, passes through an N-1 stage valid pipeline.
  - When the delayed valid is high, the aligned row {col0..colN-1} is pushed into the FIFO.
- Writes are accepted only while in COLLECT. A delayed valid arriving in DRAIN or IDLE is discarded.
- row_cnt ($clog2(N+1) bits) clears on entry to COLLECT and increments per write.
- FIFO behaviour:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits plus an occupancy count of $clog2(DEPTH+1) bits.
  - Pointers wrap from DEPTH-1 to 0.
  - A pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Push to a full FIFO cannot occur because DEPTH >= N.
- Pop while empty is a no-op.
- Consumers may pop during COLLECT; rows are visible as soon as they are written.
- out_data is undefined when out_valid is low. Verification checks it only when out_valid is high.
- Arithmetic: none. Data passes through bit-exact.

## Timing

- Reset values:
  - State is IDLE; busy, done and out_valid are 0.
  - FIFO occupancy, pointers, row_cnt and the valid pipeline are 0.
  - Data registers are 0.
- Latency: with in_valid at cycle t, the row is written at the edge ending cycle t+N-1. out_valid is high from cycle t+N, provided the FIFO was empty.
- Throughput is one row per cycle in and one row per cycle out.
- busy goes high the cycle after start. It goes low in the same cycle that done is high.
- start in the same cycle as the DRAIN->IDLE transition is ignored.
- A reset asserted mid-job clears all state immediately. In-flight and stored rows are lost and done is not pulsed.
- in_valid before start, or while in DRAIN, produces no write and does not affect row_cnt.

## Structure

- Shared package result_pkg holds:
  - the state enum rb_state_t (IDLE, COLLECT, DRAIN);
  - a function computing the de-skew depth for column j (N-1-j).
- Sub-module row_fifo has parameters DEPTH and WIDTH (N*DATA_SIZE packed row) and ports push, pop, wdata, rdata, empty, full and count. The de-skew logic and FSM stay in result_buffer.

## Test plan

- N=2: start; in_valid at cycle 1 with psum_in[0]=10; psum_in[1]=20 at cycle 2. Second row follows: psum_in[0]=30 at cycle 2, psum_in[1]=40 at cycle 3. out_ready is held 1. Required: out rows (10,20) then (30,40) at consecutive cycles, then a done pulse, then busy=0.
- Same stimulus with out_ready=0 until cycle 10. Required: out_valid held with (10,20) stable. After ready rises, rows are popped on consecutive cycles and done follows.
- in_valid pulses before start and after entering DRAIN (values 99,99). Required: no extra rows output; exactly two rows per job.
- N=4, DEPTH=4, rows (1,2,3,4)..(13,14,15,16), with out_ready toggling every cycle. Required: four rows in order, pointer wrap exercised, one done pulse.
- reset asserted after the first row is written but before it is popped. Required: out_valid=0, busy=0, done=0 immediately; a subsequent job outputs only its own rows.
- start asserted while busy. Required: ignored, and the job completes with one done pulse.
